// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the seven-segment display arbiter.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned BCD_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [NUM_DIGITS-1:0] BLANK_ALL = 6'b111111;

endpackage

// File: rtl/seg_lzb_mask.sv
// Leading-zero blank mask for a packed BCD word; bit NUM_DIGITS-1 is the MSD.
module seg_lzb_mask
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = seg_pkg::NUM_DIGITS
) (
    input  logic [NUM_DIGITS*BCD_W-1:0] bcd,
    input  logic                        lzb_en,
    output logic [NUM_DIGITS-1:0]       mask
);

    logic leading;

    // Walk from the MSD down; the LSD is never visited, so it is never blanked.
    always_comb begin
        mask    = '0;
        leading = lzb_en;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            if (leading && (bcd[(NUM_DIGITS-1-k)*BCD_W +: BCD_W] == '0)) begin
                mask[NUM_DIGITS-1-k] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Two-source display arbiter with minimum hold time, round-robin handover and
// registered BCD digits plus leading-zero blank mask.
module seg_disp_arbiter
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = seg_pkg::NUM_DIGITS,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0,
    input  logic [NUM_DIGITS*BCD_W-1:0] data0,
    input  logic                        req1,
    input  logic [NUM_DIGITS*BCD_W-1:0] data1,
    input  logic                        lzb_en,
    output logic                        gnt0,
    output logic                        gnt1,
    output logic [NUM_DIGITS*BCD_W-1:0] disp_bcd,
    output logic [NUM_DIGITS-1:0]       disp_blank
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("seg_disp_arbiter: HOLD_CYCLES must be at least 2");
    end
    if (CNT_W < 32 && (64'(HOLD_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_width
        $error("seg_disp_arbiter: CNT_W too narrow for HOLD_CYCLES");
    end

    state_t                      state;
    state_t                      state_nxt;
    logic [CNT_W-1:0]            hold_cnt;
    logic                        hold_done;
    logic [NUM_DIGITS*BCD_W-1:0] bcd_nxt;
    logic [NUM_DIGITS-1:0]       mask_nxt;

    assign hold_done = (hold_cnt == HOLD_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req1)      state_nxt = OWN1;
                else if (req0) state_nxt = OWN0;
            end
            OWN0: begin
                if (hold_done) begin
                    if (req1)       state_nxt = OWN1;
                    else if (!req0) state_nxt = IDLE;
                end
            end
            OWN1: begin
                if (hold_done) begin
                    if (req0)       state_nxt = OWN0;
                    else if (!req1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Digits follow the next-state owner, so grant and data appear together;
    // an owner that has dropped its request leaves the display frozen.
    always_comb begin
        bcd_nxt = disp_bcd;
        if ((state_nxt == OWN0) && req0) begin
            bcd_nxt = data0;
        end else if ((state_nxt == OWN1) && req1) begin
            bcd_nxt = data1;
        end
    end

    seg_lzb_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lzb (
        .bcd    (bcd_nxt),
        .lzb_en (lzb_en),
        .mask   (mask_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            disp_bcd   <= '0;
            disp_blank <= BLANK_ALL;
        end else begin
            state      <= state_nxt;
            gnt0       <= (state_nxt == OWN0);
            gnt1       <= (state_nxt == OWN1);
            disp_bcd   <= bcd_nxt;
            disp_blank <= (state_nxt == IDLE) ? BLANK_ALL : mask_nxt;
            if ((state_nxt != state) || (state_nxt == IDLE)) begin
                hold_cnt <= '0;
            end else if (!hold_done) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Self-checking bench for seg_disp_arbiter: directed scenarios plus randomized
// traffic compared each cycle against a behavioural ownership model.
module tb_seg_disp_arbiter;

    localparam int HOLD = 4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        req0   = 1'b0;
    logic        req1   = 1'b0;
    logic        lzb_en = 1'b0;
    logic [23:0] data0  = '0;
    logic [23:0] data1  = '0;
    logic        gnt0;
    logic        gnt1;
    logic [23:0] disp_bcd;
    logic [5:0]  disp_blank;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    seg_disp_arbiter #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .data0      (data0),
        .req1       (req1),
        .data1      (data1),
        .lzb_en     (lzb_en),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .disp_bcd   (disp_bcd),
        .disp_blank (disp_blank)
    );

    always #5 clk = ~clk;

    // owner: -1 none, else requester index; held: cycles owned so far, saturating
    typedef struct {
        int          owner;
        int          held;
        logic [23:0] bcd;
        logic [5:0]  blank;
    } mstate_t;

    mstate_t m = '{-1, 0, 24'h0, 6'h3f};

    function automatic logic [5:0] lzb_ref(logic [23:0] v, logic en);
        int          lz;
        int          msk;
        logic [23:0] t;
        lz = 0;
        t  = v;
        if (!en) return 6'd0;
        while (lz < 5 && t[23:20] == 4'd0) begin
            lz++;
            t = t << 4;
        end
        msk = ((1 << lz) - 1) << (6 - lz);
        return msk[5:0];
    endfunction

    function automatic mstate_t model_step(mstate_t s, logic r0, logic r1,
                                           logic [23:0] d0, logic [23:0] d1, logic en);
        mstate_t n;
        logic    r_own;
        logic    r_oth;
        n = s;
        r_own = (s.owner == 1) ? r1 : r0;
        r_oth = (s.owner == 1) ? r0 : r1;
        if (s.owner < 0) begin
            n.owner = r1 ? 1 : (r0 ? 0 : -1);
        end else if (s.held == HOLD - 1) begin
            if (r_oth)       n.owner = 1 - s.owner;
            else if (!r_own) n.owner = -1;
        end
        if (n.owner != s.owner)                 n.held = 0;
        else if (n.owner >= 0 && s.held < HOLD - 1) n.held = s.held + 1;
        if (n.owner == 0 && r0) n.bcd = d0;
        if (n.owner == 1 && r1) n.bcd = d1;
        n.blank = (n.owner < 0) ? 6'h3f : lzb_ref(n.bcd, en);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{-1, 0, 24'h0, 6'h3f};
        else        m <= model_step(m, req0, req1, data0, data1, lzb_en);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_gnt0",  32'(gnt0), 32'(m.owner == 0));
            check("model_gnt1",  32'(gnt1), 32'(m.owner == 1));
            check("model_bcd",   32'(disp_bcd), 32'(m.bcd));
            check("model_blank", 32'(disp_blank), 32'(m.blank));
            check("one_grant",   32'(gnt0 & gnt1), 32'd0);
        end
    end

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v;
        int          lz;
        v  = '0;
        lz = $urandom_range(0, 6);
        for (int d = 0; d < 6; d++) begin
            if (d < lz)                           v = v << 4;
            else if ($urandom_range(0, 9) == 0)   v = (v << 4) | 24'($urandom_range(10, 15));
            else                                  v = (v << 4) | 24'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        cmp_on = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_gnt0",  32'(gnt0), 32'd0);
        check("rst_gnt1",  32'(gnt1), 32'd0);
        check("rst_bcd",   32'(disp_bcd), 32'h0);
        check("rst_blank", 32'(disp_blank), 32'h3f);
        @(negedge clk);
        rst_n = 1'b1;

        // single requester with leading zeros
        req0 = 1'b1; data0 = 24'h000123; lzb_en = 1'b1;
        @(negedge clk);
        check("s1_gnt0",  32'(gnt0), 32'd1);
        check("s1_bcd",   32'(disp_bcd), 32'h000123);
        check("s1_blank", 32'(disp_blank), 32'b111000);
        req0 = 1'b0;
        repeat (6) @(negedge clk);
        check("s1_idle_blank", 32'(disp_blank), 32'h3f);

        // simultaneous requests from idle: requester 1 wins
        req0 = 1'b1; req1 = 1'b1; data1 = 24'h999999;
        @(negedge clk);
        check("s2_gnt1",  32'(gnt1), 32'd1);
        check("s2_gnt0",  32'(gnt0), 32'd0);
        check("s2_bcd",   32'(disp_bcd), 32'h999999);
        check("s2_blank", 32'(disp_blank), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk);

        // no preemption before the hold expires
        req0 = 1'b1; data0 = 24'h000555;
        @(negedge clk);
        check("s3_gnt0_entry", 32'(gnt0), 32'd1);
        @(negedge clk);
        req1 = 1'b1; data1 = 24'h010203;
        repeat (2) @(negedge clk);
        check("s3_gnt0_held", 32'(gnt0), 32'd1);
        check("s3_gnt1_wait", 32'(gnt1), 32'd0);
        @(negedge clk);
        check("s3_gnt1_sw",  32'(gnt1), 32'd1);
        check("s3_gnt0_sw",  32'(gnt0), 32'd0);
        check("s3_bcd",      32'(disp_bcd), 32'h010203);
        check("s3_blank",    32'(disp_blank), 32'b100000);
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk);

        // owner drops its request early: display freezes, then idles
        req0 = 1'b1; data0 = 24'h000042;
        @(negedge clk);
        check("s4_bcd_live", 32'(disp_bcd), 32'h000042);
        req0 = 1'b0; data0 = 24'h777777;
        repeat (3) @(negedge clk);
        check("s4_gnt0_frozen", 32'(gnt0), 32'd1);
        check("s4_bcd_frozen",  32'(disp_bcd), 32'h000042);
        @(negedge clk);
        check("s4_gnt0_idle", 32'(gnt0), 32'd0);
        check("s4_blank_idle", 32'(disp_blank), 32'h3f);

        // both requesting continuously: alternate every HOLD cycles, 1 first
        req0 = 1'b1; req1 = 1'b1; data0 = 24'h111111; data1 = 24'h222222;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("s5_gnt1", 32'(gnt1), 32'(((t / HOLD) % 2) == 0));
            check("s5_gnt0", 32'(gnt0), 32'(((t / HOLD) % 2) == 1));
        end

        // asynchronous reset in the middle of an OWN1 grant
        #2 rst_n = 1'b0;
        #1;
        check("s6_gnt1_rst",  32'(gnt1), 32'd0);
        check("s6_bcd_rst",   32'(disp_bcd), 32'h0);
        check("s6_blank_rst", 32'(disp_blank), 32'h3f);
        req1 = 1'b0; req0 = 1'b1; data0 = 24'h000777;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("s6_gnt0",  32'(gnt0), 32'd1);
        check("s6_bcd",   32'(disp_bcd), 32'h000777);
        check("s6_blank", 32'(disp_blank), 32'b111000);
        req0 = 1'b0;
        repeat (6) @(negedge clk);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) req0 = ~req0;
            if ($urandom_range(0, 6) == 0) req1 = ~req1;
            if ($urandom_range(0, 1) == 0) data0 = rand_bcd();
            if ($urandom_range(0, 1) == 0) data1 = rand_bcd();
            if ($urandom_range(0, 19) == 0) lzb_en = ~lzb_en;
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
